// File: rtl/req_router4.sv
// Request router: one-entry output register fans a request to one of four targets.
// An order FIFO of target indices returns the responses upstream in request order.
module req_router4 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic [WIDTH-1:0]   req_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic [3:0]         rsp_in_valid,
  output logic [3:0]         rsp_in_ready,
  input  logic [4*WIDTH-1:0] rsp_in_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             full_q, full_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       order_mem_q [DEPTH];

  logic             out_fire;
  logic             accept;
  logic             pop;
  logic             nonempty;
  logic [1:0]       head;
  logic [WIDTH-1:0] rsp_slice [4];

  // A full order FIFO blocks new requests even when the output register could take one.
  always_comb begin
    out_fire  = full_q && out_ready[sel_q];
    req_ready = (!full_q || out_fire) && (count_q < DEPTH_C);
    accept    = req_valid && req_ready;
    full_d    = full_q;
    sel_d     = sel_q;
    data_d    = data_q;
    if (accept) begin
      full_d = 1'b1;
      sel_d  = req_sel;
      data_d = req_data;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
    out_valid = full_q ? (4'b0001 << sel_q) : 4'b0000;
    out_data  = data_q;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rsp_slice[i] = rsp_in_data[i*WIDTH +: WIDTH];
    end
    nonempty     = (count_q != '0);
    head         = order_mem_q[rd_ptr_q];
    rsp_valid    = nonempty && rsp_in_valid[head];
    rsp_data     = rsp_slice[head];
    rsp_in_ready = (nonempty && rsp_ready) ? (4'b0001 << head) : 4'b0000;
    pop          = rsp_valid && rsp_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      sel_q    <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      full_q   <= full_d;
      sel_q    <= sel_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload and order storage are only observed while marked valid, so they skip reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (accept) begin
      order_mem_q[wr_ptr_q] <= req_sel;
    end
  end

endmodule

// File: tb/tb_req_router4.sv
// Bench for req_router4: directed vector table, hand-written corner sequences,
// then randomized traffic compared against a queue-based reference model.
module tb_req_router4;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_sel;
  logic [WIDTH-1:0]   req_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [3:0]         rsp_in_valid;
  logic [3:0]         rsp_in_ready;
  logic [4*WIDTH-1:0] rsp_in_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rv;
    logic [1:0] sel;
    logic [31:0] data;
    logic [3:0] ordy;
    logic [3:0] rivld;
    logic       rrdy;
    logic       e_rr;
    logic [3:0] e_ov;
    logic [31:0] e_od;
    logic       e_rv;
    logic [3:0] e_rir;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs [11];

  // Reference model: outstanding requests as a queue of target indices.
  bit          m_full;
  logic [1:0]  m_sel;
  logic [31:0] m_data;
  int          m_order [$];

  req_router4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_data     (req_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .rsp_in_valid (rsp_in_valid),
    .rsp_in_ready (rsp_in_ready),
    .rsp_in_data  (rsp_in_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    req_valid    = 1'b0;
    req_sel      = 2'd0;
    req_data     = '0;
    out_ready    = 4'hF;
    rsp_in_valid = 4'h0;
    rsp_ready    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic rv, input logic [1:0] sel, input logic [31:0] data,
                       input logic [3:0] ordy, input logic [3:0] rivld, input logic rrdy);
    @(negedge clk);
    req_valid    = rv;
    req_sel      = sel;
    req_data     = data;
    out_ready    = ordy;
    rsp_in_valid = rivld;
    rsp_ready    = rrdy;
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.rv, v.sel, v.data, v.ordy, v.rivld, v.rrdy);
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("vec%0d req_ready", idx), 64'(req_ready), 64'(v.e_rr));
    check($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(v.e_ov));
    check($sformatf("vec%0d rsp_valid", idx), 64'(rsp_valid), 64'(v.e_rv));
    check($sformatf("vec%0d rsp_in_ready", idx), 64'(rsp_in_ready), 64'(v.e_rir));
    if (v.e_ov != 4'h0) check($sformatf("vec%0d out_data", idx), 64'(out_data), 64'(v.e_od));
    if (v.e_rv) check($sformatf("vec%0d rsp_data", idx), 64'(rsp_data), 64'(v.e_rd));
  endtask

  // Compare current outputs against the model, then advance it across the coming edge.
  task automatic model_step(input int cyc);
    bit         fire, e_rr, e_rv, nonempty;
    logic [3:0] e_ov, e_rir;
    int         head;
    fire     = m_full && out_ready[m_sel];
    e_rr     = (!m_full || fire) && (m_order.size() < DEPTH);
    e_ov     = m_full ? (4'b0001 << m_sel) : 4'b0000;
    nonempty = (m_order.size() > 0);
    head     = nonempty ? m_order[0] : 0;
    e_rv     = nonempty && rsp_in_valid[head];
    e_rir    = (nonempty && rsp_ready) ? (4'b0001 << head) : 4'b0000;
    check($sformatf("rand%0d req_ready", cyc), 64'(req_ready), 64'(e_rr));
    check($sformatf("rand%0d out_valid", cyc), 64'(out_valid), 64'(e_ov));
    check($sformatf("rand%0d rsp_valid", cyc), 64'(rsp_valid), 64'(e_rv));
    check($sformatf("rand%0d rsp_in_ready", cyc), 64'(rsp_in_ready), 64'(e_rir));
    if (m_full) check($sformatf("rand%0d out_data", cyc), 64'(out_data), 64'(m_data));
    if (e_rv) check($sformatf("rand%0d rsp_data", cyc), 64'(rsp_data),
                    64'(rsp_in_data[head*WIDTH +: WIDTH]));
    if (e_rv && rsp_ready) void'(m_order.pop_front());
    if (req_valid && e_rr) begin
      m_full = 1'b1;
      m_sel  = req_sel;
      m_data = req_data;
      m_order.push_back(int'(req_sel));
    end else if (fire) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    int fires;
    rst_n       = 1'b0;
    rsp_in_data = '0;
    set_idle();

    vecs[0]  = '{1'b1, 2'd0, 32'h100, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 32'h0,   1'b0, 4'h0, 32'h0};
    vecs[1]  = '{1'b1, 2'd1, 32'h101, 4'hF, 4'h0, 1'b0, 1'b1, 4'h1, 32'h100, 1'b0, 4'h0, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 32'h102, 4'hF, 4'h0, 1'b0, 1'b1, 4'h2, 32'h101, 1'b0, 4'h0, 32'h0};
    vecs[3]  = '{1'b1, 2'd3, 32'h103, 4'hF, 4'h0, 1'b0, 1'b1, 4'h4, 32'h102, 1'b0, 4'h0, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 32'h0,   4'hF, 4'h0, 1'b0, 1'b0, 4'h8, 32'h103, 1'b0, 4'h0, 32'h0};
    vecs[5]  = '{1'b1, 2'd0, 32'h104, 4'hF, 4'h1, 1'b1, 1'b0, 4'h0, 32'h0,   1'b1, 4'h1, 32'hC0DE0000};
    vecs[6]  = '{1'b1, 2'd0, 32'h104, 4'hF, 4'h0, 1'b0, 1'b1, 4'h0, 32'h0,   1'b0, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,   4'hF, 4'hA, 1'b1, 1'b0, 4'h1, 32'h104, 1'b1, 4'h2, 32'hC0DE0001};
    vecs[8]  = '{1'b0, 2'd0, 32'h0,   4'hF, 4'h4, 1'b1, 1'b1, 4'h0, 32'h0,   1'b1, 4'h4, 32'hC0DE0002};
    vecs[9]  = '{1'b0, 2'd0, 32'h0,   4'hF, 4'h1, 1'b1, 1'b1, 4'h0, 32'h0,   1'b0, 4'h8, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 32'h0,   4'hF, 4'h8, 1'b0, 1'b1, 4'h0, 32'h0,   1'b1, 4'h0, 32'hC0DE0003};

    // Reset state and single request latency.
    do_reset();
    #1;
    check("reset req_ready", 64'(req_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    drive(1'b1, 2'd2, 32'hA5A5_0001, 4'hF, 4'h0, 1'b0);
    check("first req_ready", 64'(req_ready), 64'(1));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'h0, 1'b1);
    check("first out_valid", 64'(out_valid), 64'(4'b0100));
    check("first out_data", 64'(out_data), 64'(32'hA5A5_0001));
    check("first rsp_in_ready", 64'(rsp_in_ready), 64'(4'b0100));
    check("first rsp_valid", 64'(rsp_valid), 64'(0));

    // Back-to-back, FIFO full, pop and in-order responses.
    do_reset();
    rsp_in_data = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
    end

    // Non-head target responds first and must wait its turn.
    do_reset();
    rsp_in_data = {32'h33, 32'h0, 32'h11, 32'h0};
    drive(1'b1, 2'd1, 32'h1, 4'hF, 4'h0, 1'b0);
    drive(1'b1, 2'd3, 32'h3, 4'hF, 4'h0, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'h8, 1'b0);
    check("order t3 early rsp_valid", 64'(rsp_valid), 64'(0));
    check("order t3 early rsp_in_ready", 64'(rsp_in_ready), 64'(4'b0000));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'h8, 1'b1);
    check("order t3 held rsp_valid", 64'(rsp_valid), 64'(0));
    check("order t3 held ready bit", 64'(rsp_in_ready[3]), 64'(0));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'hA, 1'b1);
    check("order first rsp_valid", 64'(rsp_valid), 64'(1));
    check("order first rsp_data", 64'(rsp_data), 64'(32'h11));
    check("order first rsp_in_ready", 64'(rsp_in_ready), 64'(4'b0010));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'hA, 1'b1);
    check("order second rsp_valid", 64'(rsp_valid), 64'(1));
    check("order second rsp_data", 64'(rsp_data), 64'(32'h33));
    check("order second rsp_in_ready", 64'(rsp_in_ready), 64'(4'b1000));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'hA, 1'b1);
    check("order empty rsp_valid", 64'(rsp_valid), 64'(0));
    check("order empty rsp_in_ready", 64'(rsp_in_ready), 64'(0));

    // Stalled target holds the output register stable, then fires once.
    do_reset();
    fires = 0;
    drive(1'b1, 2'd2, 32'hD2D2_0002, 4'b1011, 4'h0, 1'b0);
    check("stall accept req_ready", 64'(req_ready), 64'(1));
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2'd0, 32'h0BAD, 4'b1011, 4'h0, 1'b0);
      if (out_valid[2] && out_ready[2]) fires++;
      check($sformatf("stall%0d out_valid", c), 64'(out_valid), 64'(4'b0100));
      check($sformatf("stall%0d out_data", c), 64'(out_data), 64'(32'hD2D2_0002));
      check($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'(0));
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 2'd0, 32'h0, 4'hF, 4'h0, 1'b0);
      if (out_valid[2] && out_ready[2]) fires++;
    end
    check("stall release out_valid", 64'(out_valid), 64'(0));
    check("stall single fire", 64'(fires), 64'(1));

    // Asynchronous reset with requests in flight.
    do_reset();
    drive(1'b1, 2'd0, 32'h10, 4'hF, 4'h0, 1'b0);
    drive(1'b1, 2'd1, 32'h11, 4'hF, 4'h0, 1'b0);
    drive(1'b1, 2'd2, 32'h12, 4'hF, 4'h0, 1'b0);
    drive(1'b0, 2'd0, 32'h0, 4'h0, 4'h1, 1'b1);
    check("inflight out_valid", 64'(out_valid), 64'(4'b0100));
    check("inflight rsp_valid", 64'(rsp_valid), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid), 64'(0));
    check("async rsp_valid", 64'(rsp_valid), 64'(0));
    check("async rsp_in_ready", 64'(rsp_in_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rsp_in_valid = 4'hF;
    #1;
    check("post reset req_ready", 64'(req_ready), 64'(1));
    check("post reset rsp_valid", 64'(rsp_valid), 64'(0));
    drive(1'b0, 2'd0, 32'h0, 4'hF, 4'hF, 1'b1);
    check("stale rsp_valid", 64'(rsp_valid), 64'(0));
    check("stale rsp_in_ready", 64'(rsp_in_ready), 64'(0));
    check("stale out_valid", 64'(out_valid), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    m_full = 1'b0;
    m_sel  = 2'd0;
    m_data = '0;
    m_order.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      req_valid    = ($urandom_range(0, 3) != 0);
      req_sel      = 2'($urandom_range(0, 3));
      req_data     = $urandom;
      out_ready    = 4'($urandom) | 4'($urandom);
      rsp_in_valid = 4'($urandom);
      rsp_ready    = ($urandom_range(0, 2) != 0);
      rsp_in_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_step(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
